// File: rtl/timer_counter.sv
// Countdown datapath for the timer: ms/sec/min/hr binary fields stepped by
// controller pulses, with same-cycle borrow flags for cascading decrements.
module timer_counter #(
  parameter int unsigned MS_MAX  = 999,
  parameter int unsigned SEC_MAX = 59,
  parameter int unsigned MIN_MAX = 59,
  parameter int unsigned HR_MAX  = 23
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_clear,
  input  logic       i_ms_up,
  input  logic       i_ms_down,
  input  logic       i_sec_up,
  input  logic       i_sec_down,
  input  logic       i_min_up,
  input  logic       i_min_down,
  input  logic       i_hr_up,
  input  logic       i_hr_down,
  output logic [9:0] o_ms,
  output logic [5:0] o_sec,
  output logic [5:0] o_min,
  output logic [4:0] o_hr,
  output logic       o_ms_borrowdown,
  output logic       o_sec_borrowdown,
  output logic       o_min_borrowdown,
  output logic       o_allzero
);

  localparam logic [9:0] MS_TOP  = 10'(MS_MAX);
  localparam logic [5:0] SEC_TOP = 6'(SEC_MAX);
  localparam logic [5:0] MIN_TOP = 6'(MIN_MAX);
  localparam logic [4:0] HR_TOP  = 5'(HR_MAX);

  logic [9:0] ms_q, ms_d;
  logic [5:0] sec_q, sec_d;
  logic [5:0] min_q, min_d;
  logic [4:0] hr_q, hr_d;

  // Wrap tests use only ==top and ==0 so an out-of-range value still steps
  // predictably until a clear recovers it.
  function automatic logic [5:0] step6(input logic [5:0] v, input logic up,
                                       input logic dn, input logic [5:0] top);
    logic [5:0] r;
    r = v;
    if (up && !dn)      r = (v == top)   ? 6'd0 : v + 6'd1;
    else if (dn && !up) r = (v == 6'd0)  ? top  : v - 6'd1;
    return r;
  endfunction

  function automatic logic [4:0] step5(input logic [4:0] v, input logic up,
                                       input logic dn, input logic [4:0] top);
    logic [4:0] r;
    r = v;
    if (up && !dn)      r = (v == top)   ? 5'd0 : v + 5'd1;
    else if (dn && !up) r = (v == 5'd0)  ? top  : v - 5'd1;
    return r;
  endfunction

  always_comb begin
    ms_d  = ms_q;
    sec_d = step6(sec_q, i_sec_up, i_sec_down, SEC_TOP);
    min_d = step6(min_q, i_min_up, i_min_down, MIN_TOP);
    hr_d  = step5(hr_q, i_hr_up, i_hr_down, HR_TOP);
    if (i_ms_up)        ms_d = '0;
    else if (i_ms_down) ms_d = (ms_q == '0) ? MS_TOP : ms_q - 10'd1;
    if (i_clear) begin
      ms_d  = '0;
      sec_d = '0;
      min_d = '0;
      hr_d  = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      ms_q  <= '0;
      sec_q <= '0;
      min_q <= '0;
      hr_q  <= '0;
    end else begin
      ms_q  <= ms_d;
      sec_q <= sec_d;
      min_q <= min_d;
      hr_q  <= hr_d;
    end
  end

  assign o_ms  = ms_q;
  assign o_sec = sec_q;
  assign o_min = min_q;
  assign o_hr  = hr_q;

  assign o_ms_borrowdown  = i_ms_down  & (ms_q  == '0);
  assign o_sec_borrowdown = i_sec_down & (sec_q == '0);
  assign o_min_borrowdown = i_min_down & (min_q == '0);
  assign o_allzero = (ms_q == '0) && (sec_q == '0) && (min_q == '0) && (hr_q == '0);

endmodule

// File: tb/tb_timer_counter.sv
// Bench for timer_counter: directed steps plus random pulses, checked against
// a modular-arithmetic model and a total-milliseconds countdown model.
module tb_timer_counter;

  localparam int MS_MAX  = 999;
  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;
  localparam int HR_MAX  = 23;

  logic       i_clk = 1'b0;
  logic       i_rstn;
  logic       i_clear, i_ms_up, i_ms_down, i_sec_up, i_sec_down;
  logic       i_min_up, i_min_down, i_hr_up, i_hr_down;
  logic [9:0] o_ms;
  logic [5:0] o_sec, o_min;
  logic [4:0] o_hr;
  logic       o_ms_borrowdown, o_sec_borrowdown, o_min_borrowdown, o_allzero;

  timer_counter dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_clear(i_clear),
    .i_ms_up(i_ms_up), .i_ms_down(i_ms_down),
    .i_sec_up(i_sec_up), .i_sec_down(i_sec_down),
    .i_min_up(i_min_up), .i_min_down(i_min_down),
    .i_hr_up(i_hr_up), .i_hr_down(i_hr_down),
    .o_ms(o_ms), .o_sec(o_sec), .o_min(o_min), .o_hr(o_hr),
    .o_ms_borrowdown(o_ms_borrowdown), .o_sec_borrowdown(o_sec_borrowdown),
    .o_min_borrowdown(o_min_borrowdown), .o_allzero(o_allzero)
  );

  always #5 i_clk = ~i_clk;

  int n_pass = 0;
  int n_total = 0;
  int m_ms = 0, m_sec = 0, m_min = 0, m_hr = 0;
  int c_total = 0;
  int c_errs = 0;
  logic last_bms, last_bsec;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic inputs_low();
    i_clear = 0; i_ms_up = 0; i_ms_down = 0; i_sec_up = 0; i_sec_down = 0;
    i_min_up = 0; i_min_down = 0; i_hr_up = 0; i_hr_down = 0;
  endtask

  task automatic chk_fields(input string tag);
    chk({tag, "_ms"},  32'(o_ms),  32'(m_ms));
    chk({tag, "_sec"}, 32'(o_sec), 32'(m_sec));
    chk({tag, "_min"}, 32'(o_min), 32'(m_min));
    chk({tag, "_hr"},  32'(o_hr),  32'(m_hr));
    chk({tag, "_allzero"}, 32'(o_allzero), 32'(m_ms == 0 && m_sec == 0 && m_min == 0 && m_hr == 0));
  endtask

  // One clock with the given pulses; borrows checked before the edge, fields after.
  task automatic pulse(input logic clr, input logic msu, input logic msd,
                       input logic su, input logic sd, input logic mu,
                       input logic md, input logic hu, input logic hd);
    i_clear = clr; i_ms_up = msu; i_ms_down = msd; i_sec_up = su; i_sec_down = sd;
    i_min_up = mu; i_min_down = md; i_hr_up = hu; i_hr_down = hd;
    #1;
    chk("ms_borrow",  32'(o_ms_borrowdown),  32'(msd && m_ms == 0));
    chk("sec_borrow", 32'(o_sec_borrowdown), 32'(sd && m_sec == 0));
    chk("min_borrow", 32'(o_min_borrowdown), 32'(md && m_min == 0));
    @(posedge i_clk); #1;
    if (clr) begin
      m_ms = 0; m_sec = 0; m_min = 0; m_hr = 0;
    end else begin
      if (msu)      m_ms = 0;
      else if (msd) m_ms = (m_ms + MS_MAX) % (MS_MAX + 1);
      if (su && !sd)      m_sec = (m_sec + 1) % (SEC_MAX + 1);
      else if (sd && !su) m_sec = (m_sec + SEC_MAX) % (SEC_MAX + 1);
      if (mu && !md)      m_min = (m_min + 1) % (MIN_MAX + 1);
      else if (md && !mu) m_min = (m_min + MIN_MAX) % (MIN_MAX + 1);
      if (hu && !hd)      m_hr = (m_hr + 1) % (HR_MAX + 1);
      else if (hd && !hu) m_hr = (m_hr + HR_MAX) % (HR_MAX + 1);
    end
    inputs_low();
    chk_fields("pulse");
  endtask

  // Controller-style countdown: ms_down held, higher downs fed from borrows.
  task automatic cascade(input int n);
    for (int i = 0; i < n; i++) begin
      i_ms_down = 1; #1;
      i_sec_down = o_ms_borrowdown; #1;
      i_min_down = o_sec_borrowdown; #1;
      i_hr_down = o_min_borrowdown; #1;
      last_bms = o_ms_borrowdown;
      last_bsec = o_sec_borrowdown;
      if (last_bms !== 1'(c_total % 1000 == 0)) c_errs++;
      if (last_bsec !== 1'(c_total % 60000 == 0)) c_errs++;
      @(posedge i_clk); #1;
      c_total--;
      if (int'(o_ms)  != c_total % 1000)            c_errs++;
      if (int'(o_sec) != (c_total / 1000) % 60)     c_errs++;
      if (int'(o_min) != (c_total / 60000) % 60)    c_errs++;
      if (int'(o_hr)  != c_total / 3600000)         c_errs++;
    end
    inputs_low();
    m_ms = c_total % 1000; m_sec = (c_total / 1000) % 60;
    m_min = (c_total / 60000) % 60; m_hr = c_total / 3600000;
  endtask

  initial begin
    inputs_low();
    i_rstn = 0;
    repeat (2) @(posedge i_clk);
    #1 i_rstn = 1;
    repeat (5) @(posedge i_clk);
    #1;
    chk_fields("reset");
    chk("reset_bms",  32'(o_ms_borrowdown),  0);
    chk("reset_bsec", 32'(o_sec_borrowdown), 0);
    chk("reset_bmin", 32'(o_min_borrowdown), 0);

    repeat (61) pulse(0, 0, 0, 1, 0, 0, 0, 0, 0);
    chk("sec_up61", 32'(o_sec), 1);
    chk("sec_up61_min", 32'(o_min), 0);
    repeat (3) pulse(0, 0, 0, 0, 0, 1, 0, 0, 0);
    repeat (25) pulse(0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("min_up3", 32'(o_min), 3);
    chk("hr_up25", 32'(o_hr), 1);

    pulse(1, 0, 0, 0, 0, 0, 0, 0, 0);
    pulse(0, 0, 0, 0, 0, 1, 0, 0, 0);
    c_total = 60000;
    c_errs = 0;
    cascade(1);
    chk("casc_c0_bms",  32'(last_bms),  1);
    chk("casc_c0_bsec", 32'(last_bsec), 1);
    chk("casc_c0_ms",  32'(o_ms),  999);
    chk("casc_c0_sec", 32'(o_sec), 59);
    chk("casc_c0_min", 32'(o_min), 0);
    cascade(59999);
    chk("casc_track", 32'(c_errs), 0);
    chk("casc_end_allzero", 32'(o_allzero), 1);
    chk_fields("casc_end");

    repeat (5) pulse(0, 0, 0, 1, 0, 0, 0, 0, 0);
    pulse(0, 0, 0, 1, 1, 0, 0, 0, 0);
    chk("sec_updown_hold", 32'(o_sec), 5);
    pulse(1, 0, 0, 0, 0, 0, 0, 0, 0);
    i_sec_down = 1; #1;
    chk("sec0_borrow", 32'(o_sec_borrowdown), 1);
    @(posedge i_clk); #1;
    inputs_low();
    chk("sec0_wrap", 32'(o_sec), 59);
    m_sec = 59;

    pulse(1, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (563) pulse(0, 0, 1, 0, 0, 0, 0, 0, 0);
    chk("ms_at_437", 32'(o_ms), 437);
    i_ms_up = 1; i_ms_down = 1; #1;
    chk("ms_updown_borrow", 32'(o_ms_borrowdown), 0);
    @(posedge i_clk); #1;
    inputs_low();
    chk("ms_updown_zero", 32'(o_ms), 0);
    m_ms = 0;
    repeat (3) pulse(0, 0, 0, 1, 0, 1, 0, 1, 0);
    pulse(1, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("clear_hr_up", 32'(o_hr), 0);
    chk("clear_allzero", 32'(o_allzero), 1);

    for (int i = 0; i < 300; i++)
      pulse($urandom_range(0, 31) == 0, $urandom_range(0, 7) == 0,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    pulse(1, 0, 0, 0, 0, 0, 0, 0, 0);
    pulse(0, 0, 0, 0, 0, 0, 0, 1, 0);
    pulse(0, 0, 0, 0, 0, 0, 0, 1, 0);
    c_total = 2 * 3600000;
    c_errs = 0;
    cascade(100);
    chk("cd2h_track", 32'(c_errs), 0);
    chk("cd2h_hr",  32'(o_hr),  1);
    chk("cd2h_min", 32'(o_min), 59);
    chk("cd2h_sec", 32'(o_sec), 59);
    chk("cd2h_ms",  32'(o_ms),  900);

    i_ms_down = 1; i_sec_down = 1; i_min_up = 1; i_hr_down = 1;
    #3 i_rstn = 0;
    #1;
    m_ms = 0; m_sec = 0; m_min = 0; m_hr = 0;
    chk_fields("async_rst");
    chk("async_rst_bms", 32'(o_ms_borrowdown), 1);
    @(posedge i_clk); #1;
    chk_fields("in_rst_edge");
    inputs_low();
    i_rstn = 1;
    @(posedge i_clk); #1;
    chk_fields("post_rst_idle");
    pulse(0, 0, 1, 0, 0, 0, 0, 0, 0);
    chk("post_rst_ms", 32'(o_ms), 999);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/timer_counter.md
Name: timer_counter

Overview:
- Countdown datapath for the timer: four cascaded BCD-free binary fields (ms, sec, min, hr) that respond to per-field up/down step pulses from the timer control FSM.
- Returns the current field values and per-field borrow flags to the controller. The controller uses the borrow flags to cascade decrements into the next field in the same cycle.
- Sits between the timer control FSM and the display formatter. It has no mode knowledge of its own; every change is commanded by a pulse.

Parameters:
- MS_MAX, 999, terminal value of the ms field (wrap target on borrow).
- SEC_MAX, 59, terminal value of the sec field.
- MIN_MAX, 59, terminal value of the min field.
- HR_MAX, 23, terminal value of the hr field.

Ports:
- i_clk  input  1  system clock, all state on rising edge.
- i_rstn  input  1  asynchronous active-low reset.
- i_clear  input  1  synchronous clear of all fields to 0; has priority over all step pulses.
- i_ms_up  input  1  ms field: clear to 0 this cycle (set-mode ms zeroing).
- i_ms_down  input  1  ms field: decrement by 1.
- i_sec_up  input  1  sec field: increment by 1.
- i_sec_down  input  1  sec field: decrement by 1.
- i_min_up  input  1  min field: increment by 1.
- i_min_down  input  1  min field: decrement by 1.
- i_hr_up  input  1  hr field: increment by 1.
- i_hr_down  input  1  hr field: decrement by 1.
- o_ms  output  10  current ms value, 0..MS_MAX.
- o_sec  output  6  current sec value, 0..SEC_MAX.
- o_min  output  6  current min value, 0..MIN_MAX.
- o_hr  output  5  current hr value, 0..HR_MAX.
- o_ms_borrowdown  output  1  combinational: i_ms_down & (o_ms == 0).
- o_sec_borrowdown  output  1  combinational: i_sec_down & (o_sec == 0).
- o_min_borrowdown  output  1  combinational: i_min_down & (o_min == 0).
- o_allzero  output  1  combinational: all four fields == 0.

Behaviour:
- Reset:
  - i_rstn low asynchronously forces o_ms, o_sec, o_min and o_hr to 0.
  - Borrow outputs follow their equations; all are 0 unless the matching down input is high.
  - o_allzero = 1.
- Latency:
  - Field registers update on the rising edge after a pulse.
  - Borrow flags are combinational in the same cycle as the down pulse. There is no combinational path from any borrow output to any down input inside this block.
- Priority per field, highest first:
  - i_clear.
  - up and down both high: hold the value (sec, min, hr).
  - up alone.
  - down alone.
  - hold.
- ms field:
  - i_ms_up loads 0. i_ms_up has priority over i_ms_down.
  - i_ms_down at 0 loads MS_MAX; otherwise ms-1.
- sec field:
  - Down at 0 loads SEC_MAX; otherwise sec-1.
  - Up at SEC_MAX loads 0; otherwise sec+1.
  - Up never generates a carry into min; set-mode edits are field-local.
- min field: same rules as sec, using MIN_MAX.
- hr field:
  - Down at 0 loads HR_MAX; otherwise hr-1.
  - Up at HR_MAX loads 0; otherwise hr+1.
  - No borrow output for hr; the controller stops before hr underflows.
- Cascade:
  - The controller asserts ms_down and sec_down in the same cycle when o_ms_borrowdown is high. Example: 00:01:00.000 becomes 00:00:59.999 in one edge.
  - The block must handle all simultaneous down pulses independently; each field uses its own pre-edge value.
- Out-of-range values cannot be reached. If present (e.g. after a parameter change), up/down use the ==MAX and ==0 tests only, and i_clear recovers the field.
- Reset mid-operation: immediate async clear; pulses during reset are ignored.

Test Plan:
- Reset then idle 5 cycles -> all fields 0, o_allzero=1, all borrow flags 0.
- From 0: pulse sec_up ×61 -> o_sec=1 (wrap at 59→0), o_min stays 0. Then min_up ×3 and hr_up ×25 -> o_min=3, o_hr=1.
- Load 00:01:00.000, then hold ms_down high, with sec_down driven from o_ms_borrowdown and min_down from o_sec_borrowdown. Required:
  - Cycle 0: o_ms_borrowdown=1 and o_sec_borrowdown=1.
  - After the edge: 00:00:59.999.
  - Continue 59999 more cycles -> 00:00:00.000, o_allzero=1.
- sec at 5, assert sec_up and sec_down together for 1 cycle -> o_sec stays 5. At sec=0, sec_down alone -> o_sec_borrowdown=1 during that cycle, o_sec=59 after.
- ms at 437, i_ms_up and i_ms_down together -> o_ms=0, o_ms_borrowdown=0 in that cycle. i_clear with hr_up high -> all fields 0.
- Count down 02:00:00.000 for 100 cycles, then drop i_rstn mid-cycle -> outputs go to 0 before the next clock edge. Release reset -> counting resumes from 0 only on new pulses.
